// File: rtl/soc_system_step_gen_pkg.sv
// Shared definitions for the multi-channel stepper pulse generator:
// register offsets, CTRL bit positions and the per-channel state encoding.
package soc_system_step_gen_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_STEPS  = 2'd2;
  localparam logic [1:0] REG_REMAIN = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_DIR      = 1;
  localparam int CTRL_START    = 2;
  localparam int CTRL_ABORT    = 3;
  localparam int CTRL_IRQ_EN   = 4;
  localparam int CTRL_DONE_CLR = 5;
  localparam int CTRL_BUSY     = 6;
  localparam int CTRL_DONE     = 7;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW
  } state_t;

endpackage

// File: rtl/soc_system_step_gen_if.sv
// Avalon-MM slave bus of the step generator, as seen from the HPS lightweight bridge.
interface soc_system_step_gen_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_system_step_gen_ch.sv
// One stepper channel: CTRL/PERIOD/STEPS registers, the SETUP/HIGH/LOW pulse
// sequencer with its timer, the REMAIN counter and the registered driver outputs.
module soc_system_step_gen_ch
  import soc_system_step_gen_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int PULSE_CYCLES = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        step_out,
  output logic        dir_out,
  output logic        en_out
);

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE      = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] PULSE_M1   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_BIAS   = CNT_W'(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2 * PULSE_CYCLES);

  state_t           state;
  logic             en_q, dir_q, irq_en_q, done_q;
  logic [CNT_W-1:0] period_q, steps_q, remain_q, timer_q, period_lat_q;

  logic             ctrl_wr, abort, start, done_clr, done_set, dir_next, last_step;
  logic [CNT_W-1:0] eff_period;

  assign ctrl_wr    = wr_en && (reg_sel == REG_CTRL);
  assign abort      = ctrl_wr && wdata[CTRL_ABORT];
  assign start      = ctrl_wr && wdata[CTRL_START] && !abort;
  assign done_clr   = ctrl_wr && wdata[CTRL_DONE_CLR];
  assign dir_next   = ctrl_wr ? wdata[CTRL_DIR] : dir_q;
  assign eff_period = (period_q < MIN_PERIOD) ? MIN_PERIOD : period_q;
  assign last_step  = (state == LOW) && (timer_q == '0) && (remain_q == ONE);
  assign done_set   = !abort && (last_step || ((state == IDLE) && start && (steps_q == '0)));

  assign en_out = en_q;
  assign irq    = done_q && irq_en_q;

  // NOTE: non-blocking assignments for every register so all state updates
  // see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      en_q         <= 1'b0;
      dir_q        <= 1'b0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      period_q     <= '0;
      steps_q      <= '0;
      remain_q     <= '0;
      timer_q      <= '0;
      period_lat_q <= '0;
      step_out     <= 1'b0;
      dir_out      <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en_q     <= wdata[CTRL_EN];
        dir_q    <= wdata[CTRL_DIR];
        irq_en_q <= wdata[CTRL_IRQ_EN];
      end
      if (wr_en && (reg_sel == REG_PERIOD)) period_q <= wdata[CNT_W-1:0];
      if (wr_en && (reg_sel == REG_STEPS))  steps_q  <= wdata[CNT_W-1:0];

      if (done_set)      done_q <= 1'b1;
      else if (done_clr) done_q <= 1'b0;

      // Abort overrides whatever the sequencer would do this edge.
      if (abort) begin
        state    <= IDLE;
        step_out <= 1'b0;
        remain_q <= '0;
        timer_q  <= '0;
      end else begin
        case (state)
          IDLE: begin
            dir_out <= dir_next;
            if (start && (steps_q != '0)) begin
              remain_q <= steps_q;
              timer_q  <= PULSE;
              state    <= SETUP;
            end
          end
          SETUP: begin
            if (timer_q == '0) begin
              state        <= HIGH;
              step_out     <= 1'b1;
              timer_q      <= PULSE_M1;
              period_lat_q <= eff_period;
            end else begin
              timer_q <= timer_q - ONE;
            end
          end
          HIGH: begin
            if (timer_q == '0) begin
              state    <= LOW;
              step_out <= 1'b0;
              timer_q  <= period_lat_q - LOW_BIAS;
            end else begin
              timer_q <= timer_q - ONE;
            end
          end
          LOW: begin
            if (timer_q == '0) begin
              remain_q <= remain_q - ONE;
              if (remain_q == ONE) begin
                state <= IDLE;
              end else begin
                state        <= HIGH;
                step_out     <= 1'b1;
                timer_q      <= PULSE_M1;
                period_lat_q <= eff_period;
              end
            end else begin
              timer_q <= timer_q - ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // NOTE: rdata gets a default before the case so no latch is inferred.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL: begin
        rdata[CTRL_EN]     = en_q;
        rdata[CTRL_DIR]    = dir_q;
        rdata[CTRL_IRQ_EN] = irq_en_q;
        rdata[CTRL_BUSY]   = (state != IDLE);
        rdata[CTRL_DONE]   = done_q;
      end
      REG_PERIOD: rdata[CNT_W-1:0] = period_q;
      REG_STEPS:  rdata[CNT_W-1:0] = steps_q;
      default:    rdata[CNT_W-1:0] = remain_q;
    endcase
  end

endmodule

// File: rtl/soc_system_step_gen.sv
// Multi-channel stepper pulse generator top: Avalon-MM address decode,
// zero-wait-state read mux and the interrupt OR over all channels.
module soc_system_step_gen
  import soc_system_step_gen_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PULSE_CYCLES = 100,
  parameter int ADDR_W       = $clog2(NUM_CH) + 2
) (
  input  logic                     clk,
  input  logic                     reset,
  soc_system_step_gen_if.slave     bus,
  output logic                     irq,
  output logic [NUM_CH-1:0]        step_out,
  output logic [NUM_CH-1:0]        dir_out,
  output logic [NUM_CH-1:0]        en_out
);

  logic              wr;
  logic [31:0]       ch_sel;
  logic [31:0]       ch_rdata [NUM_CH];
  logic [NUM_CH-1:0] ch_irq;

  assign wr     = bus.chipselect && !bus.write_n;
  assign ch_sel = 32'(bus.address >> 2);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    soc_system_step_gen_ch #(
      .CNT_W        (CNT_W),
      .PULSE_CYCLES (PULSE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr && (ch_sel == 32'(gi))),
      .reg_sel  (bus.address[1:0]),
      .wdata    (bus.writedata),
      .rdata    (ch_rdata[gi]),
      .irq      (ch_irq[gi]),
      .step_out (step_out[gi]),
      .dir_out  (dir_out[gi]),
      .en_out   (en_out[gi])
    );
  end

  // Addresses beyond the last channel read as zero.
  always_comb begin
    bus.readdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 32'(i)) bus.readdata = ch_rdata[i];
    end
  end

  assign irq = |ch_irq;

endmodule

// File: tb/tb_soc_system_step_gen.sv
// Bench for soc_system_step_gen: register table, timed burst sequences,
// abort/irq/dir corner cases, randomized concurrent bursts and async reset.
module tb_soc_system_step_gen;
  import soc_system_step_gen_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int PC     = 4;
  localparam int ADDR_W = 4;
  localparam int CH_W   = ADDR_W - 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              irq;
  logic [NUM_CH-1:0] step_out, dir_out, en_out;

  soc_system_step_gen_if #(.ADDR_W(ADDR_W)) bus ();

  soc_system_step_gen #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .PULSE_CYCLES (PC),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .irq      (irq),
    .step_out (step_out),
    .dir_out  (dir_out),
    .en_out   (en_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge; the write lands on the next rising edge and the
  // task returns at the falling edge after it.
  task automatic bus_write(input int ch, input logic [1:0] r, input logic [31:0] d);
    bus.address    = {CH_W'(ch), r};
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input int ch, input logic [1:0] r, output logic [31:0] d);
    bus.address    = {CH_W'(ch), r};
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  // Reference model: burst timeline from the START write edge (k = 0).
  function automatic int eff_of(input int p);
    return (p < 2 * PC) ? 2 * PC : p;
  endfunction

  function automatic logic exp_step(input int k, input int p, input int n);
    int e, r;
    e = eff_of(p);
    r = k - PC - 1;
    if (r < 0 || r >= n * e) return 1'b0;
    return (r % e) < PC;
  endfunction

  function automatic int exp_remain(input int k, input int p, input int n);
    int e, r, c;
    e = eff_of(p);
    r = k - PC - 1;
    if (r < 0) return n;
    c = r / e;
    return (c >= n) ? 0 : n - c;
  endfunction

  logic [31:0] rd;
  int          rises[$];
  int          highs;
  logic [31:0] rem_log[$];
  logic [31:0] ctrl_log[$];

  task automatic capture(input int ch, input int ncyc);
    logic prev;
    prev = 1'b0;
    highs = 0;
    rises.delete();
    rem_log.delete();
    ctrl_log.delete();
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) @(negedge clk);
      bus_read(ch, REG_REMAIN, rd);
      rem_log.push_back(rd);
      bus_read(ch, REG_CTRL, rd);
      ctrl_log.push_back(rd);
      if (step_out[ch] && !prev) rises.push_back(k);
      if (step_out[ch]) highs++;
      prev = step_out[ch];
    end
  endtask

  typedef struct {
    logic        wr;
    int          ch;
    logic [1:0]  r;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required < 20000", cyc);
    $fatal(1);
  end

  initial begin
    int t0, k, prev;
    int per_r [NUM_CH];
    int n_r   [NUM_CH];
    int t0_r  [NUM_CH];
    logic d_r  [NUM_CH];
    logic ie_r [NUM_CH];
    logic [NUM_CH-1:0] exp_s, exp_d;
    logic [31:0] cw;
    logic any_ie;
    int span;

    vecs[0]  = '{1'b1, 1, REG_CTRL,   32'h0000_0013, 32'h0000_0013, 1'b0};
    vecs[1]  = '{1'b1, 1, REG_CTRL,   32'hFFFF_FF40, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b1, 1, REG_PERIOD, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 1, REG_STEPS,  32'hA5A5_0003, 32'hA5A5_0003, 1'b0};
    vecs[4]  = '{1'b1, 1, REG_STEPS,  32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b1, 1, REG_REMAIN, 32'h0000_0055, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b1, 1, REG_CTRL,   32'h0000_0015, 32'h0000_0091, 1'b1};
    vecs[7]  = '{1'b1, 1, REG_CTRL,   32'h0000_0035, 32'h0000_0091, 1'b1};
    vecs[8]  = '{1'b1, 1, REG_CTRL,   32'h0000_0031, 32'h0000_0011, 1'b0};
    vecs[9]  = '{1'b1, 2, REG_STEPS,  32'h0001_2345, 32'h0001_2345, 1'b0};
    vecs[10] = '{1'b0, 1, REG_STEPS,  32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, 3, REG_CTRL,   32'h0000_0000, 32'h0000_0000, 1'b0};

    reset          = 1'b1;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // Reset state
    @(negedge clk);
    check("reset step_out", 32'(step_out), 32'h0);
    check("reset dir_out",  32'(dir_out),  32'h0);
    check("reset en_out",   32'(en_out),   32'h0);
    check("reset irq",      32'(irq),      32'h0);
    for (int a = 0; a < 16; a++) begin
      bus_read(a / 4, 2'(a % 4), rd);
      check($sformatf("reset readdata a%0d", a), rd, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Register table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].ch, vecs[i].r, vecs[i].wd);
      bus_read(vecs[i].ch, vecs[i].r, rd);
      check($sformatf("vec%0d readdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
      check($sformatf("vec%0d step_out", i), 32'(step_out), 32'h0);
    end

    // Burst A: PERIOD 20, STEPS 3
    bus_write(0, REG_PERIOD, 32'd20);
    bus_write(0, REG_STEPS, 32'd3);
    bus_write(0, REG_CTRL, 32'h07);
    capture(0, 71);
    check("A busy after start", 32'(ctrl_log[0][CTRL_BUSY]), 32'h1);
    check("A pulse count", 32'(rises.size()), 32'd3);
    if (rises.size() == 3) begin
      check("A first rise", 32'(rises[0]), 32'd5);
      check("A spacing 1-2", 32'(rises[1] - rises[0]), 32'd20);
      check("A spacing 2-3", 32'(rises[2] - rises[1]), 32'd20);
    end
    check("A high cycles", 32'(highs), 32'd12);
    check("A remain k5",  rem_log[5],  32'd3);
    check("A remain k25", rem_log[25], 32'd2);
    check("A remain k45", rem_log[45], 32'd1);
    check("A remain k65", rem_log[65], 32'd0);
    check("A done k64", 32'(ctrl_log[64][CTRL_DONE]), 32'h0);
    check("A done k65", 32'(ctrl_log[65][CTRL_DONE]), 32'h1);
    check("A busy k65", 32'(ctrl_log[65][CTRL_BUSY]), 32'h0);
    check("A dir_out", 32'(dir_out[0]), 32'h1);
    bus_write(0, REG_CTRL, 32'h21);

    // Burst B: PERIOD below the minimum clamps to 2*PULSE_CYCLES
    bus_write(0, REG_PERIOD, 32'd3);
    bus_write(0, REG_STEPS, 32'd2);
    bus_write(0, REG_CTRL, 32'h05);
    capture(0, 30);
    check("B pulse count", 32'(rises.size()), 32'd2);
    if (rises.size() == 2) check("B clamped spacing", 32'(rises[1] - rises[0]), 32'd8);
    check("B high cycles", 32'(highs), 32'd8);
    check("B done", 32'(ctrl_log[29][CTRL_DONE]), 32'h1);
    bus_write(0, REG_CTRL, 32'h21);

    // D: ch1 long burst aborted after 10 steps, ABORT together with START
    bus_write(1, REG_PERIOD, 32'd8);
    bus_write(1, REG_STEPS, 32'd100);
    bus_write(1, REG_CTRL, 32'h15);
    repeat (86) @(negedge clk);
    check("D step before abort", 32'(step_out[1]), 32'(exp_step(86, 8, 100)));
    bus_read(1, REG_REMAIN, rd);
    check("D remain before abort", rd, 32'(exp_remain(86, 8, 100)));
    bus_write(1, REG_CTRL, 32'h1D);
    check("D step after abort", 32'(step_out[1]), 32'h0);
    bus_read(1, REG_REMAIN, rd);
    check("D remain after abort", rd, 32'h0);
    bus_read(1, REG_CTRL, rd);
    check("D ctrl after abort", rd, 32'h11);
    check("D irq after abort", 32'(irq), 32'h0);
    repeat (20) @(negedge clk);
    check("D no restart", 32'(step_out[1]), 32'h0);
    bus_read(1, REG_CTRL, rd);
    check("D idle later", rd, 32'h11);

    // E: ch2 irq burst with a DIR change and a START while busy
    bus_write(2, REG_CTRL, 32'h11);
    bus_write(2, REG_PERIOD, 32'd8);
    bus_write(2, REG_STEPS, 32'd3);
    bus_write(2, REG_CTRL, 32'h15);
    t0 = cyc;
    rises.delete();
    prev = 0;
    while (cyc - t0 < 36) begin
      k = cyc - t0;
      if (k < 29) check($sformatf("E dir held k%0d", k), 32'(dir_out[2]), 32'h0);
      if (k >= 31) check($sformatf("E dir applied k%0d", k), 32'(dir_out[2]), 32'h1);
      if (step_out[2] && prev == 0) rises.push_back(k);
      prev = int'(step_out[2]);
      if (k == 10)      bus_write(2, REG_CTRL, 32'h13);
      else if (k == 14) bus_write(2, REG_CTRL, 32'h17);
      else              @(negedge clk);
    end
    check("E pulse count", 32'(rises.size()), 32'd3);
    if (rises.size() == 3) check("E last rise", 32'(rises[2]), 32'd21);
    check("E irq at done", 32'(irq), 32'h1);
    bus_read(2, REG_CTRL, rd);
    check("E ctrl at done", rd, 32'h93);
    bus_write(2, REG_CTRL, 32'h33);
    check("E irq after clear", 32'(irq), 32'h0);

    // Randomized concurrent bursts on all channels
    for (int round = 0; round < 4; round++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        per_r[ch] = int'($urandom_range(1, 30));
        n_r[ch]   = int'($urandom_range(1, 5));
        d_r[ch]   = 1'($urandom_range(0, 1));
        ie_r[ch]  = 1'($urandom_range(0, 1));
        cw = 32'h1 | (32'(d_r[ch]) << 1) | (32'(ie_r[ch]) << 4);
        bus_write(ch, REG_CTRL, cw | 32'h20);
        bus_write(ch, REG_PERIOD, 32'(per_r[ch]));
        bus_write(ch, REG_STEPS, 32'(n_r[ch]));
      end
      span = 0;
      any_ie = 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cw = 32'h5 | (32'(d_r[ch]) << 1) | (32'(ie_r[ch]) << 4);
        bus_write(ch, REG_CTRL, cw);
        t0_r[ch] = cyc;
        exp_d[ch] = d_r[ch];
        any_ie |= ie_r[ch];
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
        k = t0_r[ch] - t0_r[0] + PC + 1 + n_r[ch] * eff_of(per_r[ch]);
        if (k > span) span = k;
      end
      span += 4;
      while (cyc - t0_r[0] < span) begin
        for (int ch = 0; ch < NUM_CH; ch++)
          exp_s[ch] = exp_step(cyc - t0_r[ch], per_r[ch], n_r[ch]);
        check($sformatf("R%0d step_out", round), 32'(step_out), 32'(exp_s));
        check($sformatf("R%0d dir_out", round), 32'(dir_out), 32'(exp_d));
        check($sformatf("R%0d en_out", round), 32'(en_out), 32'hF);
        k = cyc % NUM_CH;
        bus_read(k, REG_REMAIN, rd);
        check($sformatf("R%0d ch%0d remain", round, k), rd,
              32'(exp_remain(cyc - t0_r[k], per_r[k], n_r[k])));
        @(negedge clk);
      end
      check($sformatf("R%0d irq", round), 32'(irq), 32'(any_ie));
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cw = 32'h81 | (32'(d_r[ch]) << 1) | (32'(ie_r[ch]) << 4);
        bus_read(ch, REG_CTRL, rd);
        check($sformatf("R%0d ch%0d ctrl", round, ch), rd, cw);
        bus_write(ch, REG_CTRL, (cw & 32'h13) | 32'h20);
      end
    end

    // Asynchronous reset in the middle of a burst
    bus_write(3, REG_PERIOD, 32'd8);
    bus_write(3, REG_STEPS, 32'd5);
    bus_write(3, REG_CTRL, 32'h17);
    repeat (6) @(negedge clk);
    check("mid-burst step high", 32'(step_out[3]), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async reset step_out", 32'(step_out), 32'h0);
    check("async reset dir_out",  32'(dir_out),  32'h0);
    check("async reset en_out",   32'(en_out),   32'h0);
    check("async reset irq",      32'(irq),      32'h0);
    for (int a = 0; a < 16; a++) begin
      bus_read(a / 4, 2'(a % 4), rd);
      check($sformatf("async reset readdata a%0d", a), rd, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_system_step_gen.md
Name: soc_system_step_gen

Overview:
- Multi-channel stepper pulse generator with an Avalon-MM slave. Successor to the single-channel 3-bit step/dir/enable PIO.
- Software programs the period, step count and direction per channel. Hardware then emits a timed step burst, with busy/done status and an interrupt.
- Sits between the HPS lightweight bridge and the motor-driver pins.

Parameters:
- NUM_CH, 4, number of independent motor channels (1..8).
- CNT_W, 32, width of the PERIOD and STEPS counters (2..32).
- PULSE_CYCLES, 100, step high time and dir-setup time in clk cycles (>=1).
- ADDR_W, $clog2(NUM_CH)+2, derived; 4 registers per channel.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_W  word address; [ADDR_W-1:2] = channel, [1:0] = register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  combinational read data, zero wait states; unused bits 0.
- irq  out  1  level interrupt.
- step_out  out  NUM_CH  step pulses, registered.
- dir_out  out  NUM_CH  direction, registered.
- en_out  out  NUM_CH  driver enable, registered.

Behaviour:
- Write condition: chipselect && !write_n, taking effect at the clk edge.
- Reset: all outputs, registers and counters are 0; every FSM is in IDLE.
- Register map per channel:
  - 0 CTRL
    - W: bit0 EN; bit1 DIR; bit2 START (pulse, not stored); bit3 ABORT (pulse); bit4 IRQ_EN; bit5 DONE_CLR (pulse).
    - R: bit0 EN, bit1 DIR, bit4 IRQ_EN, bit6 BUSY, bit7 DONE.
  - 1 PERIOD: cycles between step rising edges. Effective period = max(PERIOD, 2*PULSE_CYCLES).
  - 2 STEPS: number of steps for the next START.
  - 3 REMAIN: read-only, steps still to issue (0 when idle).
- en_out = EN. dir_out loads DIR only while the channel is in IDLE. A DIR write while busy is stored but not applied until IDLE.
- FSM per channel: IDLE, SETUP, HIGH, LOW; timer is CNT_W bits.
  - IDLE + START, STEPS != 0: REMAIN <= STEPS, dir_out <= DIR, go SETUP with timer = PULSE_CYCLES. BUSY reads 1 the cycle after the write.
  - IDLE + START, STEPS == 0: DONE <= 1 next cycle, stay IDLE, no pulse.
  - SETUP: on timer expiry go HIGH; step_out rises PULSE_CYCLES+1 cycles after the START write edge.
  - HIGH: step_out = 1 for PULSE_CYCLES cycles, then go LOW.
  - LOW: step_out = 0 for (effective period - PULSE_CYCLES) cycles, then REMAIN -= 1.
    - REMAIN now 0: set DONE, go IDLE.
    - Otherwise go HIGH.
- PERIOD write while busy: sampled at each HIGH entry, so it applies from the next step. STEPS write while busy: stored, used at the next START only.
- START while busy: ignored.
- ABORT: from any state, next edge gives step_out = 0, REMAIN = 0, IDLE; DONE is not set.
- ABORT and START in the same write: ABORT wins.
- DONE is sticky. DONE_CLR clears it. DONE set and DONE_CLR in the same cycle: set wins.
- irq = OR over channels of (DONE & IRQ_EN).
- EN = 0 does not stop the FSM. Software aborts explicitly.
- A reset assertion mid-burst immediately forces all outputs to 0 (asynchronous).

Decomposition:
- Shared package soc_system_step_gen_pkg holds:
  - register offsets REG_CTRL = 0, REG_PERIOD = 1, REG_STEPS = 2, REG_REMAIN = 3;
  - CTRL bit indices;
  - state enum {IDLE, SETUP, HIGH, LOW}.
- Sub-module soc_system_step_gen_ch: one channel (registers, FSM, timer, REMAIN counter, outputs), instantiated NUM_CH times via generate.
- The top level contains only address decode, the read mux and the irq OR.

Test Plan:
- Reset with outputs toggling mid-burst -> all outputs 0 within the reset cycle; readdata 0 at all addresses.
- PULSE_CYCLES = 4, ch0 PERIOD = 20, STEPS = 3, CTRL = 0x07 -> check each of the following:
  - step_out[0] rises at write+5;
  - 3 pulses of 4 cycles high, rising-edge spacing 20;
  - DONE set at the end of the 3rd LOW;
  - REMAIN reads 3, 2, 1, 0 across the burst.
- PERIOD = 3 with PULSE_CYCLES = 4 -> rising-edge spacing clamps to 8.
- ch1 STEPS = 0, START -> DONE = 1 next cycle, no pulse.
- ch1 STEPS = 100 burst, ABORT after 10 steps -> step_out = 0 next cycle, REMAIN = 0, DONE = 0, irq = 0.
- ch2 IRQ_EN = 1 burst completes -> irq = 1.
  - DONE_CLR -> irq = 0.
  - DIR toggled mid-burst -> dir_out unchanged until IDLE.
  - START while busy -> ignored, step count unchanged.
